// File: rtl/shifter_pkg.sv
// ============================================================================
// Module : shifter_pkg
// Brief  : Shared types for the sequential shift unit (op codes, FSM states).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shifter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS  = 3'b000,
        OP_SHL   = 3'b001,
        OP_SHR_A = 3'b010,
        OP_SHR_L = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_CLR   = 3'b110,
        OP_RSVD  = 3'b111
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shifter_step.sv
// ============================================================================
// Module : shifter_step
// Brief  : Combinational single-position shift/rotate step.
//          bit_out exists only when SHIFTER_FLAGS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shifter_step
    import shifter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    input  shift_op_t    op,
`ifdef SHIFTER_FLAGS_EN
    output logic         bit_out,
`endif
    output logic [N-1:0] data_next
);

    always_comb begin
        data_next = data;
        case (op)
            OP_SHL:   data_next = {data[N-2:0], 1'b0};
            OP_SHR_A: data_next = {data[N-1], data[N-1:1]};
            OP_SHR_L: data_next = {1'b0, data[N-1:1]};
            OP_ROL:   data_next = {data[N-2:0], data[N-1]};
            OP_ROR:   data_next = {data[0], data[N-1:1]};
            OP_CLR:   data_next = '0;
            default:  data_next = data;
        endcase
    end

`ifdef SHIFTER_FLAGS_EN
    // Left-moving ops lose the MSB, right-moving ops lose the LSB.
    always_comb begin
        bit_out = 1'b0;
        case (op)
            OP_SHL, OP_ROL:             bit_out = data[N-1];
            OP_SHR_A, OP_SHR_L, OP_ROR: bit_out = data[0];
            default:                    bit_out = 1'b0;
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: rtl/shifter_seq.sv
// ============================================================================
// Module : shifter_seq
// Brief  : Multi-cycle shift unit, one bit position per clock, valid/ready on
//          both sides. Optional flags (out_carry/out_zero): SHIFTER_FLAGS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shifter_seq
    import shifter_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    input  logic [OP_W-1:0] in_op,
    input  logic [AW-1:0]   in_amt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
`ifdef SHIFTER_FLAGS_EN
    output logic            out_carry,
    output logic            out_zero,
`endif
    output logic            busy
);

    state_t          r_state;
    logic [N-1:0]    r_data;
    shift_op_t       r_op;
    logic [AW-1:0]   r_cnt;
    logic [N-1:0]    w_step_data;
    shift_op_t       w_in_op;
    logic            w_single;

    assign w_in_op = shift_op_t'(in_op);

    // PASS, CLR, reserved and zero-amount commands take exactly one SHIFT
    // cycle with a non-moving op, so all commands share the same path.
    assign w_single = (w_in_op == OP_PASS) || (w_in_op == OP_CLR) ||
                      (w_in_op == OP_RSVD) || (in_amt == '0);

`ifdef SHIFTER_FLAGS_EN
    logic w_step_bit;
    logic r_carry;
    logic r_zero;

    shifter_step #(.N(N)) u_step (
        .data      (r_data),
        .op        (r_op),
        .bit_out   (w_step_bit),
        .data_next (w_step_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_carry <= w_step_bit;
            r_zero  <= (w_step_data == '0);
        end
    end

    assign out_carry = r_carry;
    assign out_zero  = r_zero;
`else
    shifter_step #(.N(N)) u_step (
        .data      (r_data),
        .op        (r_op),
        .data_next (w_step_data)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_op    <= OP_PASS;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= SHIFT;
                        if (w_single) begin
                            r_op  <= (w_in_op == OP_CLR) ? OP_CLR : OP_PASS;
                            r_cnt <= AW'(1);
                        end else begin
                            r_op  <= w_in_op;
                            r_cnt <= in_amt;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_step_data;
                    r_cnt  <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_data;

endmodule

`default_nettype wire
